// File: rtl/icache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_unit
// Description : ICache miss refill engine. Fetches one line per miss as a
//               burst, assembles the beats and writes them to the arrays.
// Revision    : 1.0 - initial release
// ============================================================================

package icache_refill_pkg;

    typedef struct packed {
        int unsigned PLEN;
        int unsigned ICACHE_BYTE_SIZE;
        int unsigned ICACHE_SET_ASSOC;
        int unsigned ICACHE_LINE_WIDTH;
    } user_cfg_t;

    typedef struct packed {
        int unsigned PLEN;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned ICACHE_OFFSET_WIDTH;
        int unsigned ICACHE_TAG_WIDTH;
        int unsigned ICACHE_SET_ASSOC_WIDTH;
    } cfg_t;

    localparam user_cfg_t c_DEFAULT_USER_CFG = '{
        PLEN:              32,
        ICACHE_BYTE_SIZE:  4096,
        ICACHE_SET_ASSOC:  4,
        ICACHE_LINE_WIDTH: 256
    };

    // Index counts set-select bits only; the tag is everything above them.
    function automatic cfg_t build_config(input user_cfg_t u);
        cfg_t c;
        c.PLEN                   = u.PLEN;
        c.ICACHE_LINE_WIDTH      = u.ICACHE_LINE_WIDTH;
        c.ICACHE_OFFSET_WIDTH    = $clog2(u.ICACHE_LINE_WIDTH / 8);
        c.ICACHE_INDEX_WIDTH     = $clog2(u.ICACHE_BYTE_SIZE / u.ICACHE_SET_ASSOC)
                                   - c.ICACHE_OFFSET_WIDTH;
        c.ICACHE_TAG_WIDTH       = u.PLEN - c.ICACHE_INDEX_WIDTH - c.ICACHE_OFFSET_WIDTH;
        c.ICACHE_SET_ASSOC_WIDTH = (u.ICACHE_SET_ASSOC > 1) ? $clog2(u.ICACHE_SET_ASSOC) : 1;
        return c;
    endfunction

endpackage

module icache_refill_unit #(
    parameter icache_refill_pkg::cfg_t CFG =
        icache_refill_pkg::build_config(icache_refill_pkg::c_DEFAULT_USER_CFG),
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  flush_i,
    input  logic                                  miss_req_valid_i,
    output logic                                  miss_req_ready_o,
    input  logic [CFG.PLEN-1:0]                   miss_req_paddr_i,
    input  logic [CFG.ICACHE_SET_ASSOC_WIDTH-1:0] miss_req_way_i,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output logic [CFG.PLEN-1:0]                   mem_req_addr_o,
    output logic [7:0]                            mem_req_len_o,
    input  logic                                  mem_rsp_valid_i,
    output logic                                  mem_rsp_ready_o,
    input  logic [BUS_WIDTH-1:0]                  mem_rsp_data_i,
    input  logic                                  mem_rsp_last_i,
    output logic                                  refill_valid_o,
    output logic [CFG.ICACHE_INDEX_WIDTH-1:0]     refill_index_o,
    output logic [CFG.ICACHE_TAG_WIDTH-1:0]       refill_tag_o,
    output logic [CFG.ICACHE_SET_ASSOC_WIDTH-1:0] refill_way_o,
    output logic [CFG.ICACHE_LINE_WIDTH-1:0]      refill_data_o,
    output logic                                  busy_o
);

    localparam int unsigned c_PLEN   = CFG.PLEN;
    localparam int unsigned c_OFF    = CFG.ICACHE_OFFSET_WIDTH;
    localparam int unsigned c_IDX    = CFG.ICACHE_INDEX_WIDTH;
    localparam int unsigned c_TAG    = CFG.ICACHE_TAG_WIDTH;
    localparam int unsigned c_BEATS  = CFG.ICACHE_LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned c_CNT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);
    localparam logic [c_PLEN-1:0]  c_LINE_MASK = ~c_PLEN'((64'd1 << c_OFF) - 64'd1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_REQ   = 3'd1;
    localparam logic [2:0] c_S_RESP  = 3'd2;
    localparam logic [2:0] c_S_WRITE = 3'd3;
    localparam logic [2:0] c_S_DRAIN = 3'd4;

    logic [2:0]                            r_state;
    logic [c_PLEN-1:0]                     r_addr;
    logic [CFG.ICACHE_SET_ASSOC_WIDTH-1:0] r_way;
    logic [c_CNT_W-1:0]                    r_cnt;
    logic [CFG.ICACHE_LINE_WIDTH-1:0]      r_line;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_S_IDLE;
            r_addr  <= '0;
            r_way   <= '0;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (miss_req_valid_i && !flush_i) begin
                        r_addr  <= miss_req_paddr_i & c_LINE_MASK;
                        r_way   <= miss_req_way_i;
                        r_cnt   <= '0;
                        r_state <= c_S_REQ;
                    end
                end
                c_S_REQ: begin
                    // A request already handed to memory must have its beats drained.
                    if (mem_req_ready_i) begin
                        r_state <= flush_i ? c_S_DRAIN : c_S_RESP;
                    end else if (flush_i) begin
                        r_state <= c_S_IDLE;
                    end
                end
                c_S_RESP: begin
                    if (flush_i) begin
                        if (mem_rsp_valid_i && mem_rsp_last_i) begin
                            r_state <= c_S_IDLE;
                        end else begin
                            r_state <= c_S_DRAIN;
                        end
                    end else if (mem_rsp_valid_i) begin
                        r_line[r_cnt*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST_BEAT) begin
                            r_state <= c_S_WRITE;
                        end
                    end
                end
                c_S_WRITE: begin
                    r_state <= c_S_IDLE;
                end
                c_S_DRAIN: begin
                    if (mem_rsp_valid_i && mem_rsp_last_i) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign miss_req_ready_o = (r_state == c_S_IDLE) && !flush_i;
    assign busy_o           = (r_state != c_S_IDLE);
    assign mem_req_valid_o  = (r_state == c_S_REQ);
    assign mem_req_addr_o   = r_addr;
    assign mem_req_len_o    = 8'(c_BEATS - 1);
    assign mem_rsp_ready_o  = (r_state == c_S_RESP) || (r_state == c_S_DRAIN);
    assign refill_valid_o   = (r_state == c_S_WRITE);
    assign refill_index_o   = r_addr[c_OFF +: c_IDX];
    assign refill_tag_o     = r_addr[c_PLEN-1 -: c_TAG];
    assign refill_way_o     = r_way;
    assign refill_data_o    = r_line;

endmodule
`default_nettype wire
